token_out: RTL and testbench

- Transmit side of the USB token path. Accepts a token request (PID type, device address, endpoint) through a start/busy handshake.
- Computes CRC5 serially over address and endpoint, then assembles the 24-bit token word.
- Shifts the word out one bit per bit-period to the serial line stage, and presents the parallel word for loopback into the token decoder.

---
 rtl/token_out.sv | 129 ++++++++++++
 tb/tb_token_out.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/token_out.sv
// USB token transmitter: serial CRC5 over addr/endp, then 24-bit word shifted out MSB first.
// Latency: first tx_bit 12 cycles after start is taken; start is ignored while a packet is in flight.
module token_out #(
  parameter int BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        start,
  input  logic [1:0]  pid_sel,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
  output logic        busy,
  output logic [23:0] packet,
  output logic        packet_valid,
  output logic        tx_valid,
  output logic        tx_bit,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CRC, SEND, DONE} state_t;

  localparam logic [3:0] PER_MAX = 4'(BIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  pid_q;
  logic [6:0]  addr_q;
  logic [3:0]  endp_q;
  logic [4:0]  crc_q;
  logic [4:0]  idx;
  logic [3:0]  per;
  logic [10:0] crc_data;
  logic        crc_d;
  logic        fb;
  logic [4:0]  crc_step;
  logic [3:0]  pid_code;
  logic        last_crc;
  logic        last_per;
  logic        last_bit;

  // CRC consumes addr LSB first, then endp LSB first
  assign crc_data = {endp_q, addr_q};
  assign crc_d    = crc_data[idx[3:0]];
  assign fb       = crc_q[4] ^ crc_d;
  assign crc_step = {crc_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  assign last_crc = (idx == 5'd10);
  assign last_per = (per == PER_MAX);
  assign last_bit = (idx == 5'd23);

  always_comb begin
    pid_code = 4'b0001;
    case (pid_q)
      2'd0:    pid_code = 4'b0001;
      2'd1:    pid_code = 4'b1001;
      2'd2:    pid_code = 4'b0101;
      default: pid_code = 4'b1101;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CRC;
      CRC:     if (last_crc) state_nxt = SEND;
      SEND:    if (last_bit && last_per) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs are registered decodes of the state, so they trail it by one cycle
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pid_q        <= 2'd0;
      addr_q       <= 7'd0;
      endp_q       <= 4'd0;
      crc_q        <= 5'd0;
      idx          <= 5'd0;
      per          <= 4'd0;
      busy         <= 1'b0;
      packet       <= 24'h0;
      packet_valid <= 1'b0;
      tx_valid     <= 1'b0;
      tx_bit       <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy         <= (state != IDLE);
      tx_valid     <= (state == SEND);
      done         <= (state == DONE);
      packet_valid <= (state == SEND) || (state == DONE);
      tx_bit       <= (state == SEND) ? packet[5'd23 - idx] : 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pid_q  <= pid_sel;
            addr_q <= addr;
            endp_q <= endp;
            crc_q  <= 5'b11111;
            idx    <= 5'd0;
            per    <= 4'd0;
          end
        end
        CRC: begin
          crc_q <= crc_step;
          if (last_crc) begin
            packet <= {pid_code, ~pid_code, addr_q, endp_q, ~crc_step};
            idx    <= 5'd0;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        SEND: begin
          if (last_per) begin
            per <= 4'd0;
            idx <= last_bit ? 5'd0 : idx + 5'd1;
          end else begin
            per <= per + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_token_out.sv
// Bench for token_out: two instances (1 and 4 cycles per bit) selected through a mux,
// randomized tokens scored against a packet model built from the field/CRC definition.
module tb_token_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L, start, sel;
  logic [1:0] pid_sel;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       start1, start4;
  logic       busy1, pv1, txv1, txb1, done1;
  logic       busy4, pv4, txv4, txb4, done4;
  logic [23:0] pkt1, pkt4;
  logic       busy_o, pv_o, txv_o, txb_o, done_o;
  logic [23:0] pkt_o;

  assign start1 = start & ~sel;
  assign start4 = start & sel;

  token_out #(.BIT_CYCLES(1)) u1 (
    .clk(clk), .reset_L(reset_L), .start(start1), .pid_sel(pid_sel), .addr(addr), .endp(endp),
    .busy(busy1), .packet(pkt1), .packet_valid(pv1), .tx_valid(txv1), .tx_bit(txb1), .done(done1)
  );

  token_out #(.BIT_CYCLES(4)) u4 (
    .clk(clk), .reset_L(reset_L), .start(start4), .pid_sel(pid_sel), .addr(addr), .endp(endp),
    .busy(busy4), .packet(pkt4), .packet_valid(pv4), .tx_valid(txv4), .tx_bit(txb4), .done(done4)
  );

  assign busy_o = sel ? busy4 : busy1;
  assign pv_o   = sel ? pv4   : pv1;
  assign txv_o  = sel ? txv4  : txv1;
  assign txb_o  = sel ? txb4  : txb1;
  assign done_o = sel ? done4 : done1;
  assign pkt_o  = sel ? pkt4  : pkt1;

  int checks = 0;
  int errors = 0;
  logic [23:0] last_pkt;
  logic [23:0] stream;
  logic [1:0]  nxt_p;
  logic [6:0]  nxt_a;
  logic [3:0]  nxt_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model(input logic [1:0] p, input logic [6:0] a, input logic [3:0] e);
    logic [3:0]  pid_tab [4];
    logic [3:0]  pid;
    logic [10:0] msg;
    logic [4:0]  c;
    pid_tab = '{4'b0001, 4'b1001, 4'b0101, 4'b1101};
    pid = pid_tab[p];
    msg = {e, a};
    c = 5'h1f;
    for (int k = 0; k < 11; k++)
      c = {c[3:0], 1'b0} ^ ((c[4] ^ msg[k]) ? 5'h05 : 5'h00);
    return {pid, ~pid, a, e, ~c};
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_pv"},   pv_o,   0);
    check({tag, "_txv"},  txv_o,  0);
    check({tag, "_txb"},  txb_o,  0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pkt"},  pkt_o,  0);
  endtask

  // Runs one token; on entry (unless chained) we sit at a negedge with the DUT idle.
  task automatic run_packet(input logic [1:0] p, input logic [6:0] a, input logic [3:0] e,
                            input bit bc4, input bit chained, input bit hold, input bit mid);
    logic [23:0] exp;
    int bc, n;
    bit seen;
    bc  = bc4 ? 4 : 1;
    exp = model(p, a, e);
    if (!chained) begin
      sel = bc4; pid_sel = p; addr = a; endp = e; start = 1'b1;
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    pid_sel = 2'($urandom); addr = 7'($urandom); endp = 4'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_rise", busy_o, 1);
      seen = txv_o;
    end
    check("first_bit_latency", n, 12);
    stream = 24'h0;
    for (int i = 0; i < 24 * bc; i++) begin
      if (i > 0) @(negedge clk);
      if (mid && i == 9 * bc) begin start = 1'b1; addr = ~a; endp = ~e; end
      if (mid && i == 10 * bc) start = hold;
      if (i == 0) last_pkt = pkt_o;
      if (i % bc == 0) stream = {stream[22:0], txb_o};
      check("tx_valid", txv_o, 1);
      check("tx_bit", txb_o, exp[23 - i / bc]);
      check("packet", pkt_o, exp);
      check("packet_valid", pv_o, 1);
    end
    @(negedge clk);
    if (hold) begin pid_sel = nxt_p; addr = nxt_a; endp = nxt_e; end
    check("done_pulse", done_o, 1);
    check("done_txv", txv_o, 0);
    check("done_pv", pv_o, 1);
    check("done_busy", busy_o, 1);
    @(negedge clk);
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
    check("post_pv", pv_o, 0);
    check("post_pkt_hold", pkt_o, exp);
  endtask

  initial begin
    int n, dcount;
    logic [1:0] rp;
    logic [6:0] ra;
    logic [3:0] re;
    reset_L = 1'b0; start = 1'b0; sel = 1'b0; pid_sel = 2'd0; addr = 7'd0; endp = 4'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_u1");
    sel = 1'b1; #1;
    check_idle_zero("reset_u4");
    sel = 1'b0;
    reset_L = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("released");

    run_packet(2'd1, 7'd0, 4'd0, 0, 0, 0, 0);
    check("in_packet", last_pkt, 24'h960008);
    check("in_stream", stream, 24'b1001_0110_0000_0000_0000_1000);
    check("in_dec_pid", last_pkt[23:20], 4'b1001);
    check("in_dec_npid", last_pkt[19:16], 4'b0110);
    check("in_dec_addr", last_pkt[15:9], 7'd0);
    check("in_dec_endp", last_pkt[8:5], 4'd0);
    check("in_dec_crc", last_pkt[4:0], 5'b01000);
    run_packet(2'd0, 7'd0, 4'd0, 0, 0, 0, 0);
    check("out_packet", last_pkt, 24'h1E0008);
    run_packet(2'd3, 7'd0, 4'd0, 0, 0, 0, 0);
    check("setup_packet", last_pkt, 24'hD20008);
    run_packet(2'd1, 7'd0, 4'd0, 1, 0, 0, 0);
    check("in_bc4_packet", last_pkt, 24'h960008);
    check("in_bc4_stream", stream, 24'h960008);

    run_packet(2'd2, 7'h55, 4'h3, 0, 0, 0, 1);
    run_packet(2'd3, 7'h2a, 4'hc, 1, 0, 0, 1);

    nxt_p = 2'd2; nxt_a = 7'h7f; nxt_e = 4'hf;
    run_packet(2'd1, 7'h11, 4'h5, 0, 0, 1, 0);
    run_packet(nxt_p, nxt_a, nxt_e, 0, 1, 0, 0);

    sel = 1'b0; pid_sel = 2'd1; addr = 7'($urandom); endp = 4'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!txv_o && n < 40) begin @(negedge clk); n++; end
    check("abort_reach_send", txv_o, 1);
    repeat (9) @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    reset_L = 1'b1;
    dcount = 0;
    repeat (40) begin @(negedge clk); if (done_o) dcount++; end
    check("abort_no_done", dcount, 0);
    check("abort_idle_busy", busy_o, 0);
    run_packet(2'd3, 7'h33, 4'h9, 0, 0, 0, 0);

    repeat (16) begin
      rp = 2'($urandom); ra = 7'($urandom); re = 4'($urandom);
      run_packet(rp, ra, re, ($urandom % 4) == 0, 0, 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
